// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Desc   : Shared register-file widths and the writeback entry type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Desc   : Synchronous FIFO, DEPTH entries (power of two) of type T.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import mips_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  T                   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full     = (r_count == c_cnt_w'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module : regfile_writeback
// Desc   : Register-file writeback arbiter: buffered load results drain
//          ahead of ALU results. Define WB_BYPASS_EN for operand forwarding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_writeback
  import mips_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  output logic [REG_ADDR_W-1:0] address_d,
  output logic [DATA_W-1:0]     data_dval,
  output logic                  write_enable,
  output logic [15:0]           write_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] address_s1,
  input  logic [REG_ADDR_W-1:0] address_s2,
  output logic                  fwd_s1_hit,
  output logic [DATA_W-1:0]     fwd_s1_data,
  output logic                  fwd_s2_hit,
  output logic [DATA_W-1:0]     fwd_s2_data
`endif
);

  wb_entry_t w_push_entry;
  wb_entry_t w_head;
  logic      w_fifo_full;
  logic      w_fifo_empty;
  logic      w_push;
  logic      w_pop;
  logic      w_alu_take;

  logic [REG_ADDR_W-1:0] r_address_d;
  logic [DATA_W-1:0]     r_data_dval;
  logic                  r_write_enable;
  logic [15:0]           r_write_count;

  assign mem_ready    = !reset && !w_fifo_full;
  assign alu_ready    = !reset && w_fifo_empty;
  assign w_push       = mem_valid && mem_ready;
  assign w_pop        = !w_fifo_empty;
  assign w_alu_take   = alu_valid && alu_ready;
  assign w_push_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (MEM_FIFO_DEPTH),
    .T     (wb_entry_t)
  ) u_mem_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // A buffered load always wins; ALU can only be taken when the FIFO is empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_address_d    <= '0;
      r_data_dval    <= '0;
      r_write_enable <= 1'b0;
      r_write_count  <= '0;
    end else begin
      if (w_pop) begin
        r_address_d    <= w_head.rd;
        r_data_dval    <= w_head.data;
        r_write_enable <= (w_head.rd != REG_ZERO);
      end else if (w_alu_take) begin
        r_address_d    <= alu_rd;
        r_data_dval    <= alu_data;
        r_write_enable <= (alu_rd != REG_ZERO);
      end else begin
        r_write_enable <= 1'b0;
      end
      if (r_write_enable) begin
        r_write_count <= r_write_count + 16'd1;
      end
    end
  end

  assign address_d    = r_address_d;
  assign data_dval    = r_data_dval;
  assign write_enable = r_write_enable;
  assign write_count  = r_write_count;

`ifdef WB_BYPASS_EN
  assign fwd_s1_hit  = r_write_enable && (r_address_d == address_s1) && (address_s1 != REG_ZERO);
  assign fwd_s2_hit  = r_write_enable && (r_address_d == address_s2) && (address_s2 != REG_ZERO);
  assign fwd_s1_data = fwd_s1_hit ? r_data_dval : '0;
  assign fwd_s2_data = fwd_s2_hit ? r_data_dval : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module : tb_regfile_writeback
// Desc   : Directed self-checking bench for regfile_writeback.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  address_d;
  logic [31:0] data_dval;
  logic        write_enable;
  logic [15:0] write_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  address_s1;
  logic [4:0]  address_s2;
  logic        fwd_s1_hit;
  logic [31:0] fwd_s1_data;
  logic        fwd_s2_hit;
  logic [31:0] fwd_s2_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback #(.MEM_FIFO_DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .address_d    (address_d),
    .data_dval    (data_dval),
    .write_enable (write_enable),
    .write_count  (write_count)
`ifdef WB_BYPASS_EN
    ,
    .address_s1   (address_s1),
    .address_s2   (address_s2),
    .fwd_s1_hit   (fwd_s1_hit),
    .fwd_s1_data  (fwd_s1_data),
    .fwd_s2_hit   (fwd_s2_hit),
    .fwd_s2_data  (fwd_s2_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_rd    = '0;
    mem_data  = '0;
`ifdef WB_BYPASS_EN
    address_s1 = '0;
    address_s2 = '0;
`endif
    tick();
    tick();
    check("rst_we",        32'(write_enable), 32'd0);
    check("rst_addr",      32'(address_d),    32'd0);
    check("rst_data",      data_dval,         32'd0);
    check("rst_count",     32'(write_count),  32'd0);
    check("rst_alu_ready", 32'(alu_ready),    32'd0);
    check("rst_mem_ready", 32'(mem_ready),    32'd0);

    reset = 1'b0;
    #1;
    check("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    check("post_rst_mem_ready", 32'(mem_ready), 32'd1);

    // ALU single write
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu1_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("alu1_we",    32'(write_enable), 32'd1);
    check("alu1_addr",  32'(address_d),    32'd5);
    check("alu1_data",  data_dval,         32'hDEADBEEF);
    check("alu1_cnt0",  32'(write_count),  32'd0);
    tick();
    check("alu1_cnt1",  32'(write_count),  32'd1);
    check("idle_we",    32'(write_enable), 32'd0);
    check("idle_addr",  32'(address_d),    32'd5);
    check("idle_data",  data_dval,         32'hDEADBEEF);

    // $zero destination: consumed, never written
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    check("zero_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("zero_we",    32'(write_enable), 32'd0);
    tick();
    check("zero_cnt",   32'(write_count),  32'd1);

    // Two loads then an ALU result held valid: commit order 3, 4, 7
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h33;
    tick();
    mem_rd = 5'd4; mem_data = 32'h44;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    check("ord_alu_stall0", 32'(alu_ready), 32'd0);
    check("ord_mem_ready",  32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    check("ord_w0_we",      32'(write_enable), 32'd1);
    check("ord_w0_addr",    32'(address_d),    32'd3);
    check("ord_w0_data",    data_dval,         32'h33);
    check("ord_alu_stall1", 32'(alu_ready),    32'd0);
    tick();
    check("ord_w1_we",      32'(write_enable), 32'd1);
    check("ord_w1_addr",    32'(address_d),    32'd4);
    check("ord_w1_data",    data_dval,         32'h44);
    check("ord_alu_go",     32'(alu_ready),    32'd1);
    tick();
    alu_valid = 1'b0;
    check("ord_w2_we",      32'(write_enable), 32'd1);
    check("ord_w2_addr",    32'(address_d),    32'd7);
    check("ord_w2_data",    data_dval,         32'h77);
    tick();
    check("ord_we_off",     32'(write_enable), 32'd0);
    check("ord_cnt",        32'(write_count),  32'd4);

    // Back-to-back loads stream through with two-cycle latency
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'h100 + 32'(i);
        #1;
        check("strm_mem_ready", 32'(mem_ready), 32'd1);
      end else begin
        mem_valid = 1'b0;
      end
      tick();
      if (i == 0 || i == 5) begin
        check("strm_we_off", 32'(write_enable), 32'd0);
      end else begin
        check("strm_we",   32'(write_enable), 32'd1);
        check("strm_addr", 32'(address_d),    32'(10 + i - 1));
        check("strm_data", data_dval,         32'h100 + 32'(i - 1));
      end
    end
    check("strm_cnt", 32'(write_count), 32'd8);

    // Reset with a buffered load and a pending write
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h2020;
    tick();
    mem_rd = 5'd21; mem_data = 32'h2121;
    tick();
    mem_valid = 1'b0;
    check("mid_pending_we", 32'(write_enable), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_we",    32'(write_enable), 32'd0);
    check("mid_rst_cnt",   32'(write_count),  32'd0);
    check("mid_rst_alu",   32'(alu_ready),    32'd0);
    reset = 1'b0;
    #1;
    check("mid_rel_alu",   32'(alu_ready),    32'd1);
    check("mid_rel_mem",   32'(mem_ready),    32'd1);
    tick();
    check("mid_no_stale",  32'(write_enable), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5A5A5;
    tick();
    alu_valid = 1'b0;
    check("mid_fresh_we",   32'(write_enable), 32'd1);
    check("mid_fresh_addr", 32'(address_d),    32'd9);
    check("mid_fresh_data", data_dval,         32'hA5A5A5A5);
`ifdef WB_BYPASS_EN
    address_s1 = 5'd9; address_s2 = 5'd0;
    #1;
    check("fwd_s1_hit",  32'(fwd_s1_hit),  32'd1);
    check("fwd_s1_data", fwd_s1_data,      32'hA5A5A5A5);
    check("fwd_s2_hit",  32'(fwd_s2_hit),  32'd0);
    check("fwd_s2_data", fwd_s2_data,      32'd0);
`endif
    tick();
    check("mid_fresh_cnt", 32'(write_count), 32'd1);

    // Drive the commit counter to its wrap point
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    repeat (65534) tick();
    alu_valid = 1'b0;
    tick();
    check("wrap_ffff", 32'(write_count), 32'h0000FFFF);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    check("wrap_we", 32'(write_enable), 32'd1);
    tick();
    check("wrap_zero", 32'(write_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
